// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB arbiter sizing, bus encodings and arbiter FSM states.
package ahb_pkg;

    localparam int unsigned NO_OF_MASTERS = 4;
    localparam int unsigned MASTER_IDX_W  = 2;
    localparam int unsigned DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;

    typedef enum logic [1:0] {
        ARB_OPEN   = 2'b00,
        ARB_LOCKED = 2'b01,
        ARB_SPLIT  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: combinational round-robin pick, searching from last+1 and wrapping.
module ahb_rr_picker #(
    parameter int unsigned NO_OF_MASTERS = ahb_pkg::NO_OF_MASTERS
) (
    input  logic [NO_OF_MASTERS-1:0]         eligible,
    input  logic [ahb_pkg::MASTER_IDX_W-1:0] last,
    output logic [NO_OF_MASTERS-1:0]         grant_c,
    output logic                             valid_c
);
    import ahb_pkg::*;

    logic [MASTER_IDX_W-1:0] idx;

    // First eligible master after the last-granted one wins.
    always_comb begin
        grant_c = '0;
        valid_c = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NO_OF_MASTERS; k++) begin
            idx = MASTER_IDX_W'((32'(last) + k) % NO_OF_MASTERS);
            if (!valid_c && eligible[idx]) begin
                grant_c[idx] = 1'b1;
                valid_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_split_arbiter.sv
// ahb_split_arbiter: AHB round-robin arbiter with lock and SPLIT/RETRY handling.
// Optional split watchdog enabled by defining AHB_SPLIT_TIMEOUT_EN.
module ahb_split_arbiter #(
    parameter int unsigned NO_OF_MASTERS  = ahb_pkg::NO_OF_MASTERS,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned SPLIT_TIMEOUT  = 64
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]         HLOCK,
    input  ahb_pkg::htrans_t                 HTRANS,
    input  logic [2:0]                       HBURST,
    input  logic                             HREADY,
    input  ahb_pkg::hresp_t                  HRESP,
    input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
    output logic [NO_OF_MASTERS-1:0]         HGRANT,
    output logic [ahb_pkg::MASTER_IDX_W-1:0] HMASTER,
    output logic                             HMASTLOCK,
    output logic [NO_OF_MASTERS-1:0]         split_mask,
    output logic [NO_OF_MASTERS-1:0]         split_timeout
);
    import ahb_pkg::*;

    localparam int unsigned  N       = NO_OF_MASTERS;
    localparam int unsigned  W       = MASTER_IDX_W;
    localparam logic [N-1:0] DEF_OH  = N'(1) << DEFAULT_MASTER;
    localparam logic [W-1:0] DEF_IDX = W'(DEFAULT_MASTER);

    // Reject configurations the index width or watchdog cannot represent.
    if (SPLIT_TIMEOUT == 0 || DEFAULT_MASTER >= NO_OF_MASTERS ||
        NO_OF_MASTERS > (1 << MASTER_IDX_W)) begin : g_bad_cfg
        $error("ahb_split_arbiter: illegal parameter combination");
    end

    function automatic logic [W-1:0] oh2idx(input logic [N-1:0] oh);
        oh2idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (oh[i]) oh2idx = W'(i);
        end
    endfunction

    arb_state_t   state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [W-1:0] hmaster_q, hmaster_d;
    logic         hmastlock_q, hmastlock_d;
    logic [W-1:0] dmaster_q, dmaster_d;
    logic [W-1:0] last_q, last_d;
    logic [N-1:0] mask_q, mask_d;

    logic [N-1:0] set_vec;
    logic [N-1:0] timeout_hit;
    logic [N-1:0] eligible;
    logic [N-1:0] pick_grant;
    logic         pick_valid;
    logic [N-1:0] new_grant;
    logic [W-1:0] new_idx;
    logic [W-1:0] grant_idx;
    logic         new_lock;
    logic         resp_first;
    logic         arb_point;
    logic         decide;

    // First response cycle detection and split-mask update; a new SPLIT beats any clear.
    always_comb begin
        resp_first = !HREADY && (HRESP == SPLIT || HRESP == RETRY);
        set_vec    = '0;
        if (!HREADY && HRESP == SPLIT && dmaster_q != DEF_IDX) begin
            set_vec = N'(1) << dmaster_q;
        end
        mask_d = (mask_q & ~HSPLIT & ~timeout_hit) | set_vec;
    end

    // Eligible requesters; the second split cycle also excludes the responding master.
    always_comb begin
        eligible = HBUSREQ & ~mask_d;
        if (state_q == ARB_SPLIT) begin
            eligible = eligible & ~(N'(1) << dmaster_q);
        end
    end

    ahb_rr_picker #(
        .NO_OF_MASTERS (N)
    ) u_picker (
        .eligible (eligible),
        .last     (last_q),
        .grant_c  (pick_grant),
        .valid_c  (pick_valid)
    );

    // Arbitration point detection and the winner of this cycle's decision.
    always_comb begin
        grant_idx = oh2idx(grant_q);
        arb_point = HREADY && (HTRANS == IDLE ||
                               (HTRANS == NONSEQ && HBURST == SINGLE) ||
                               !HBUSREQ[grant_idx]);
        new_grant = pick_valid ? pick_grant : DEF_OH;
        new_idx   = oh2idx(new_grant);
        new_lock  = HLOCK[new_idx];
        case (state_q)
            ARB_OPEN:  decide = arb_point;
            ARB_SPLIT: decide = HREADY;
            default:   decide = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= ARB_OPEN;
        else        state_q <= state_d;
    end

    // FSM next state: split/retry preempts everything, lock holds the grant.
    always_comb begin
        state_d = state_q;
        if (resp_first) begin
            state_d = ARB_SPLIT;
        end else begin
            case (state_q)
                ARB_OPEN:   if (decide && new_lock) state_d = ARB_LOCKED;
                ARB_LOCKED: if (HREADY && HTRANS == IDLE && !HLOCK[grant_idx]) state_d = ARB_OPEN;
                ARB_SPLIT:  if (HREADY) state_d = ARB_OPEN;
                default:    state_d = ARB_OPEN;
            endcase
        end
    end

    // FSM outputs: grant load on decisions, address/data phase owners on HREADY.
    always_comb begin
        grant_d     = grant_q;
        last_d      = last_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        dmaster_d   = dmaster_q;
        if (decide) begin
            grant_d = new_grant;
            last_d  = new_idx;
        end
        if (HREADY) begin
            hmaster_d   = grant_idx;
            hmastlock_d = HLOCK[grant_idx];
            dmaster_d   = hmaster_q;
        end
    end

    // Arbiter datapath registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q     <= DEF_OH;
            last_q      <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            dmaster_q   <= DEF_IDX;
            mask_q      <= '0;
        end else begin
            grant_q     <= grant_d;
            last_q      <= last_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            dmaster_q   <= dmaster_d;
            mask_q      <= mask_d;
        end
    end

`ifdef AHB_SPLIT_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(SPLIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPLIT_TIMEOUT - 1);

    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]            timeout_q, timeout_d;

    // Watchdog expiry: the edge that would bring the count to SPLIT_TIMEOUT.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            timeout_hit[i] = mask_q[i] && (cnt_q[i] == CNT_LAST);
        end
        timeout_d = timeout_hit;
    end

    // Count cycles spent masked; restart whenever the bit clears or expires.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = (mask_q[i] && mask_d[i] && !timeout_hit[i]) ? cnt_q[i] + CNT_W'(1) : '0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_q     <= '0;
            timeout_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign split_timeout = timeout_q;
`else
    assign timeout_hit   = '0;
    assign split_timeout = '0;
`endif

    assign HGRANT     = grant_q;
    assign HMASTER    = hmaster_q;
    assign HMASTLOCK  = hmastlock_q;
    assign split_mask = mask_q;

endmodule

// File: doc/ahb_split_arbiter.md
AHB_SPLIT_ARBITER -- requirements
Module: ahb_split_arbiter

Interface
REQ-001 SHALL have parameter NO_OF_MASTERS, default from ahb_pkg, meaning the number of bus masters.
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, meaning the master granted when no eligible request exists.
REQ-003 SHALL have parameter SPLIT_TIMEOUT, default 64, meaning the watchdog limit in cycles; used only under AHB_SPLIT_TIMEOUT_EN.
REQ-004 SHALL have port HCLK, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port HBUSREQ, input, NO_OF_MASTERS bits: per-master bus request.
REQ-007 SHALL have port HLOCK, input, NO_OF_MASTERS bits: per-master locked-transfer request.
REQ-008 SHALL have port HTRANS, input, htrans_t: current owner's transfer type.
REQ-009 SHALL have port HBURST, input, 3 bits: current owner's burst type; SINGLE = 0.
REQ-010 SHALL have port HREADY, input, 1 bit: bus ready.
REQ-011 SHALL have port HRESP, input, hresp_t: slave response (OKAY, ERROR, RETRY, SPLIT).
REQ-012 SHALL have port HSPLIT, input, NO_OF_MASTERS bits: OR of all split-capable slaves' re-enable pulses.
REQ-013 SHALL have port HGRANT, output, NO_OF_MASTERS bits: one-hot grant.
REQ-014 SHALL have port HMASTER, output, MASTER_IDX_W bits: index of the address-phase owner.
REQ-015 SHALL have port HMASTLOCK, output, 1 bit: address-phase owner holds lock.
REQ-016 SHALL have port split_mask, output, NO_OF_MASTERS bits: masters currently parked by SPLIT.
REQ-017 SHALL have port split_timeout, output, NO_OF_MASTERS bits: one-cycle watchdog pulse; tied 0 when the macro is absent.

Function
REQ-018 SHALL keep a registered data-phase master index, loaded from HMASTER when HREADY=1.
REQ-019 SHALL detect SPLIT on the first response cycle, HRESP=SPLIT with HREADY=0, and set split_mask[data-phase master] on the next edge.
REQ-020 SHALL never set split_mask[DEFAULT_MASTER]; a SPLIT against it SHALL be ignored.
REQ-021 SHALL clear split_mask[i] on the edge after HSPLIT[i]=1.
REQ-022 SHALL let set win when set and clear of the same bit occur in the same cycle.
REQ-023 SHALL treat master i as eligible when HBUSREQ[i]=1 and split_mask[i]=0, with the mask value as updated on that same edge.
REQ-024 SHALL use an FSM with states ARB_OPEN, ARB_LOCKED and ARB_SPLIT.
REQ-025 SHALL, in ARB_OPEN, re-arbitrate at an arbitration point: HREADY=1 and any one of HTRANS=IDLE; HTRANS=NONSEQ with HBURST=SINGLE; owner HBUSREQ=0.
REQ-026 SHALL, in ARB_OPEN, move to ARB_LOCKED when the newly granted master has HLOCK=1.
REQ-027 SHALL, in ARB_LOCKED, hold the grant; it SHALL return to ARB_OPEN when the owner's HLOCK=0 and HTRANS=IDLE with HREADY=1.
REQ-028 SHALL enter ARB_SPLIT from any state on first-cycle SPLIT or RETRY.
REQ-029 SHALL, in ARB_SPLIT, force re-arbitration on the second response cycle, excluding the split master, and then go to ARB_OPEN; lock is released.
REQ-030 SHALL select round-robin among eligible masters, starting at last-granted+1 and wrapping at NO_OF_MASTERS-1 to 0.
REQ-031 SHALL grant DEFAULT_MASTER when no master is eligible.
REQ-032 SHALL register HGRANT one cycle after the arbitration decision.
REQ-033 SHALL update HMASTER and HMASTLOCK from HGRANT and HLOCK on the next HREADY=1 edge.
REQ-034 SHALL keep HGRANT one-hot at all times.

Reset
REQ-035 SHALL, on HRESET=1 at a rising edge, set HGRANT = one-hot DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, split_mask = 0, last-granted = DEFAULT_MASTER, FSM = ARB_OPEN, and all watchdog counters and split_timeout = 0.
REQ-036 SHALL let reset asserted mid-burst or mid-split override all other events in that cycle.

Configuration
REQ-037 SHALL, with AHB_SPLIT_TIMEOUT_EN defined, keep a per-master counter that increments while split_mask[i]=1 and resets when the bit clears.
REQ-038 SHALL, with AHB_SPLIT_TIMEOUT_EN defined, clear split_mask[i] and pulse split_timeout[i] for one cycle when the counter reaches SPLIT_TIMEOUT.
REQ-039 SHALL, without AHB_SPLIT_TIMEOUT_EN, have no counters and hold split_timeout at 0, so masters stay masked until HSPLIT.

Structure
REQ-040 SHALL take NO_OF_MASTERS, MASTER_IDX_W, DATA_WIDTH, hresp_t and htrans_t from ahb_pkg, with SINGLE, IDLE and NONSEQ as package constants.
REQ-041 SHALL place round-robin selection in the combinational sub-module ahb_rr_picker (inputs eligible vector and last index; outputs one-hot grant and a valid flag).

Verification
REQ-042 SHALL verify: 4 masters, HBUSREQ=4'b1111, all transfers SINGLE -> grants cycle 1,2,3,0 on successive arbitration points after reset.
REQ-043 SHALL verify: master 2 receives SPLIT (HREADY=0, then 1) -> split_mask=4'b0100; HGRANT moves to master 3 on the second cycle; master 2 is not granted until HSPLIT[2] pulses, after which it is eligible on the next decision.
REQ-044 SHALL verify: master 1 with HLOCK=1 and an INCR burst, other requests active -> HGRANT stays master 1 and HMASTLOCK=1 until HLOCK=0 with IDLE.
REQ-045 SHALL verify: SPLIT and HSPLIT on the same master in the same cycle -> split_mask bit ends set.
REQ-046 SHALL verify: all requesters split, HBUSREQ=4'b0110, split_mask=4'b0110 -> HGRANT = DEFAULT_MASTER.
REQ-047 SHALL verify: with the macro defined and SPLIT_TIMEOUT=8, no HSPLIT after a split of master 3 -> split_timeout[3] pulses 8 cycles after the mask set and the mask clears; HRESET mid-split clears all state in one cycle.
